// File: rtl/serial_addsub.sv
// Serial adder/subtractor: takes two WIDTH-bit operands MSB first and streams back the
// WIDTH+1-bit sum or difference MSB first, with a per-bit valid strobe.
module serial_addsub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic mode_i,
    input  logic ina,
    input  logic inb,
    output logic en_o,
    output logic out,
    output logic busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0]   res_q;
    logic [CntW-1:0]  cnt_q;
    logic             mode_q;

    logic [WIDTH-1:0] a_full, b_full;
    logic [WIDTH:0]   result;

    // Operands including the bit arriving this cycle, so the result can be
    // registered on the same edge that captures the LSB.
    always_comb begin
        a_full = {a_q[WIDTH-2:0], ina};
        b_full = {b_q[WIDTH-2:0], inb};
        result = mode_q ? ({1'b0, a_full} - {1'b0, b_full})
                        : ({1'b0, a_full} + {1'b0, b_full});
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            en_o    <= 1'b0;
            out     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    en_o <= 1'b0;
                    out  <= 1'b0;
                    if (en_i) begin
                        mode_q  <= mode_i;
                        a_q     <= a_full;
                        b_q     <= b_full;
                        cnt_q   <= CntW'(1);
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    a_q <= a_full;
                    b_q <= b_full;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        res_q   <= result;
                        cnt_q   <= '0;
                        state_q <= StSend;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSend: begin
                    out   <= res_q[WIDTH];
                    en_o  <= 1'b1;
                    res_q <= {res_q[WIDTH-1:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    // Leaving here lets busy drop while the LSB is on the wire.
                    if (cnt_q == CntW'(WIDTH)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH = 2, 4 and 8.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode = 1'b0, ina = 1'b0, inb = 1'b0;
    logic en2 = 1'b0, en4 = 1'b0, en8 = 1'b0;
    logic eo2, eo4, eo8, o2, o4, o8, b2, b4, b8;

    int cur_w = 4;
    logic s_eo, s_out, s_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .en_i(en2), .mode_i(mode), .ina(ina), .inb(inb),
        .en_o(eo2), .out(o2), .busy(b2)
    );
    serial_addsub #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .en_i(en4), .mode_i(mode), .ina(ina), .inb(inb),
        .en_o(eo4), .out(o4), .busy(b4)
    );
    serial_addsub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .en_i(en8), .mode_i(mode), .ina(ina), .inb(inb),
        .en_o(eo8), .out(o8), .busy(b8)
    );

    always_comb begin
        if (cur_w == 2) begin
            s_eo = eo2; s_out = o2; s_busy = b2;
        end else if (cur_w == 4) begin
            s_eo = eo4; s_out = o4; s_busy = b4;
        end else begin
            s_eo = eo8; s_out = o8; s_busy = b8;
        end
    end

    typedef struct {
        bit         md;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (cur_w == 2) en2 = v;
        else if (cur_w == 4) en4 = v;
        else en8 = v;
    endtask

    // Drives edges 0..WIDTH-1; returns 1ns after edge WIDTH-1.
    task automatic start_load(input bit md, input logic [31:0] a, input logic [31:0] b,
                              input bit noise);
        int bad = 0;
        set_en(1'b1);
        mode = md;
        ina  = a[cur_w-1];
        inb  = b[cur_w-1];
        for (int k = 1; k < cur_w; k++) begin
            @(posedge clk); #1;
            if (s_busy !== 1'b1 || s_eo !== 1'b0 || s_out !== 1'b0) bad++;
            set_en(noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (noise) mode = 1'($urandom_range(0, 1));
            ina = a[cur_w-1-k];
            inb = b[cur_w-1-k];
        end
        @(posedge clk); #1;
        if (s_busy !== 1'b1 || s_eo !== 1'b0) bad++;
        ina = 1'($urandom_range(0, 1));
        inb = 1'($urandom_range(0, 1));
        check("load busy/en_o", bad, 0);
    endtask

    // Collects the WIDTH+1 result bits from edges WIDTH..2*WIDTH.
    task automatic collect(input bit noise, output logic [32:0] res);
        int bad = 0;
        res = '0;
        for (int i = 0; i <= cur_w; i++) begin
            @(posedge clk); #1;
            if (s_eo !== 1'b1) bad++;
            if (s_busy !== (i < cur_w)) bad++;
            res = {res[31:0], s_out};
            set_en((noise && i < cur_w) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        check("send en_o/busy", bad, 0);
    endtask

    task automatic idle_check(input string name);
        @(posedge clk); #1;
        check(name, {s_eo, s_out, s_busy}, 3'b000);
    endtask

    task automatic run_op(input string name, input bit md, input logic [31:0] a,
                          input logic [31:0] b, input logic [32:0] exp, input bit noise);
        logic [32:0] res;
        start_load(md, a, b, noise);
        collect(noise, res);
        check(name, res, exp);
        idle_check({name, " end"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] r;
        logic [7:0]  ra, rb;
        logic [8:0]  rexp;
        bit          rmd;

        vecs[0] = '{md: 1'b0, a: 8'd9,  b: 8'd7,  exp: 9'd16};
        vecs[1] = '{md: 1'b1, a: 8'd9,  b: 8'd7,  exp: 9'd2};
        vecs[2] = '{md: 1'b1, a: 8'd2,  b: 8'd5,  exp: 9'd29};
        vecs[3] = '{md: 1'b0, a: 8'd15, b: 8'd15, exp: 9'd30};
        vecs[4] = '{md: 1'b1, a: 8'd15, b: 8'd15, exp: 9'd0};
        vecs[5] = '{md: 1'b1, a: 8'd0,  b: 8'd15, exp: 9'd17};
        vecs[6] = '{md: 1'b0, a: 8'd0,  b: 8'd0,  exp: 9'd0};
        vecs[7] = '{md: 1'b0, a: 8'd8,  b: 8'd8,  exp: 9'd16};
        vecs[8] = '{md: 1'b0, a: 8'd5,  b: 8'd10, exp: 9'd15};

        cur_w = 4;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {s_eo, s_out, s_busy}, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ina = 1'($urandom_range(0, 1));
            inb = 1'($urandom_range(0, 1));
            idle_check("idle");
        end

        foreach (vecs[i]) begin
            run_op($sformatf("w4 vec%0d", i), vecs[i].md, 32'(vecs[i].a), 32'(vecs[i].b),
                   33'(vecs[i].exp), 1'b0);
        end

        // Back-to-back with ignored mid-operation strobes.
        start_load(1'b0, 32'd15, 32'd15, 1'b1);
        collect(1'b1, r);
        check("b2b first", r, 33'd30);
        start_load(1'b1, 32'd15, 32'd15, 1'b1);
        collect(1'b0, r);
        check("b2b second", r, 33'd0);
        idle_check("b2b end");

        // Reset mid-LOAD.
        set_en(1'b1); mode = 1'b0; ina = 1'b1; inb = 1'b1;
        @(posedge clk); #1;
        set_en(1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset mid-load", {s_eo, s_out, s_busy}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle_check("after reset load");

        // Reset mid-SEND while out is high.
        start_load(1'b0, 32'd15, 32'd15, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre-reset send", {s_eo, s_out, s_busy}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("reset mid-send", {s_eo, s_out, s_busy}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) idle_check("after reset send");
        run_op("w4 fresh add", 1'b0, 32'd3, 32'd1, 33'd4, 1'b0);

        cur_w = 2;
        run_op("w2 add", 1'b0, 32'd3, 32'd1, 33'd4, 1'b0);
        run_op("w2 sub", 1'b1, 32'd1, 32'd3, 33'd6, 1'b0);

        cur_w = 8;
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rmd  = 1'($urandom_range(0, 1));
            rexp = rmd ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
            run_op($sformatf("w8 rand%0d", n), rmd, 32'(ra), 32'(rb), 33'(rexp), n[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
